wb_arbiter_3x1: RTL

WB_ARBITER_3X1 -- requirements
Module: wb_arbiter_3x1

---
 rtl/wb_arbiter_pkg.sv | 22 ++
 rtl/wb_if.sv | 31 +++
 rtl/wb_rr_pick.sv | 30 +++
 rtl/wb_arbiter_3x1.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the 3-master Wishbone arbiter.
//   N_MASTERS    : number of requesting masters
//   master_idx_t : index of a master (grant / last-granted registers)
//   arb_state_e  : arbiter FSM states
//   rr_next      : round-robin successor of a master index (wraps at N_MASTERS)
package wb_arbiter_pkg;

  localparam int unsigned N_MASTERS = 3;

  typedef logic [1:0] master_idx_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StTout = 2'd2
  } arb_state_e;

  function automatic master_idx_t rr_next(master_idx_t idx);
    return (idx >= master_idx_t'(N_MASTERS - 1)) ? '0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle.
//   master modport : drives adr/cti/bte/dat_w/sel/cyc/stb/we, receives dat_r/ack/err
//   slave modport  : the mirror image
interface wb_if #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32
);

  logic [WB_ADDR_WIDTH-1:0]   adr;
  logic [2:0]                 cti;
  logic [1:0]                 bte;
  logic [WB_DATA_WIDTH-1:0]   dat_w;
  logic [WB_DATA_WIDTH-1:0]   dat_r;
  logic [WB_DATA_WIDTH/8-1:0] sel;
  logic                       cyc;
  logic                       stb;
  logic                       we;
  logic                       ack;
  logic                       err;

  modport master (
    output adr, cti, bte, dat_w, sel, cyc, stb, we,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, cti, bte, dat_w, sel, cyc, stb, we,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
//   req       : one request bit per master
//   last      : most recently granted master
//   gnt_idx   : selected master (first requester after last, wrapping, last itself checked last)
//   gnt_valid : at least one request present
module wb_rr_pick
  import wb_arbiter_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  master_idx_t          last,
  output master_idx_t          gnt_idx,
  output logic                 gnt_valid
);

  master_idx_t cand;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = last;
    for (int k = 0; k < int'(N_MASTERS); k++) begin
      cand = rr_next(cand);
      if (!gnt_valid && req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_3x1.sv
// Three-master to one-slave Wishbone arbiter with round-robin grant and slave watchdog.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   m0, m1, m2 : requesting masters (arbiter acts as their slave)
//   s0         : shared slave (arbiter acts as its master)
//   timeout_o  : one-cycle pulse when the watchdog expires
module wb_arbiter_3x1
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.slave  m2,
  wb_if.master s0,
  output logic timeout_o
);

  localparam int unsigned SelW = WB_DATA_WIDTH / 8;
  // Keep at least one bit so a disabled watchdog still elaborates.
  localparam int unsigned WdW  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [WdW-1:0] wd_t;

  localparam wd_t WdMax  = wd_t'(TIMEOUT_CYCLES);
  localparam wd_t WdLast = (TIMEOUT_CYCLES == 0) ? '0 : wd_t'(TIMEOUT_CYCLES - 1);

  arb_state_e  state_q, state_d;
  master_idx_t grant_q, grant_d;
  master_idx_t last_q, last_d;
  wd_t         wd_cnt_q, wd_cnt_d;

  logic [N_MASTERS-1:0] req;
  master_idx_t          pick_idx;
  logic                 pick_valid;

  assign req = {m2.cyc, m1.cyc, m0.cyc};

  wb_rr_pick u_pick (
    .req       (req),
    .last      (last_q),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  // Request signals of the currently granted master.
  logic [WB_ADDR_WIDTH-1:0] g_adr;
  logic [2:0]               g_cti;
  logic [1:0]               g_bte;
  logic [WB_DATA_WIDTH-1:0] g_dat_w;
  logic [SelW-1:0]          g_sel;
  logic                     g_cyc, g_stb, g_we;

  always_comb begin
    case (grant_q)
      2'd0: begin
        g_adr = m0.adr; g_cti = m0.cti; g_bte = m0.bte; g_dat_w = m0.dat_w;
        g_sel = m0.sel; g_cyc = m0.cyc; g_stb = m0.stb; g_we    = m0.we;
      end
      2'd1: begin
        g_adr = m1.adr; g_cti = m1.cti; g_bte = m1.bte; g_dat_w = m1.dat_w;
        g_sel = m1.sel; g_cyc = m1.cyc; g_stb = m1.stb; g_we    = m1.we;
      end
      default: begin
        g_adr = m2.adr; g_cti = m2.cti; g_bte = m2.bte; g_dat_w = m2.dat_w;
        g_sel = m2.sel; g_cyc = m2.cyc; g_stb = m2.stb; g_we    = m2.we;
      end
    endcase
  end

  // Reset gates the bus immediately so nothing leaks out during the reset cycle.
  logic                     fwd, in_tout;
  logic                     rsp_ack, rsp_err;
  logic [WB_DATA_WIDTH-1:0] rsp_dat;

  always_comb begin
    fwd      = !rst && (state_q == StBusy);
    in_tout  = !rst && (state_q == StTout);

    s0.adr   = fwd ? g_adr   : '0;
    s0.cti   = fwd ? g_cti   : '0;
    s0.bte   = fwd ? g_bte   : '0;
    s0.dat_w = fwd ? g_dat_w : '0;
    s0.sel   = fwd ? g_sel   : '0;
    s0.we    = fwd && g_we;
    s0.cyc   = fwd && g_cyc;
    s0.stb   = fwd && g_stb;

    rsp_ack  = fwd && s0.ack;
    rsp_err  = (fwd && s0.err) || in_tout;
    rsp_dat  = fwd ? s0.dat_r : '0;

    m0.ack   = (grant_q == 2'd0) && rsp_ack;
    m0.err   = (grant_q == 2'd0) && rsp_err;
    m0.dat_r = (grant_q == 2'd0) ? rsp_dat : '0;
    m1.ack   = (grant_q == 2'd1) && rsp_ack;
    m1.err   = (grant_q == 2'd1) && rsp_err;
    m1.dat_r = (grant_q == 2'd1) ? rsp_dat : '0;
    m2.ack   = (grant_q == 2'd2) && rsp_ack;
    m2.err   = (grant_q == 2'd2) && rsp_err;
    m2.dat_r = (grant_q == 2'd2) ? rsp_dat : '0;

    timeout_o = in_tout;
  end

  // Unanswered strobe: the only condition under which the watchdog advances.
  logic stalled;
  assign stalled = g_stb && !s0.ack && !s0.err;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_cnt_d = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!g_cyc) begin
          state_d = StIdle;
        end else if (TIMEOUT_CYCLES != 0 && stalled && wd_cnt_q == WdLast) begin
          state_d = StTout;
        end else if (stalled) begin
          wd_cnt_d = (wd_cnt_q == WdMax) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
      end
      StTout: begin
        state_d = g_cyc ? StBusy : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= master_idx_t'(N_MASTERS - 1);
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule
